// File: rtl/axi_slave_mem.sv
// AXI3 slave memory with byte-strobe writes and FIXED/INCR/WRAP bursts.
// The write (AW/W/B) and read (AR/R) paths each hold one transaction in flight.
module axi_slave_mem #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LG     = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]        MAX_SIZE    = 3'(LG);
  localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [1:0]        BURST_INCR  = 2'b01;
  localparam logic [1:0]        BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [3:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (size > MAX_SIZE) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  function automatic logic idx_err(input logic [ADDR_W-1:0] addr);
    return (addr >> LG) >= DEPTH_A;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> LG);
  endfunction

  // WRAP keeps the upper bits of the aligned window and lets only the offset roll over.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size,
                                                  input logic [3:0] len,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] win_mask;
    step     = ONE_A << size;
    inc      = addr + step;
    win_mask = ((ADDR_W'(len) + ONE_A) << size) - ONE_A;
    case (burst)
      BURST_INCR: return inc;
      BURST_WRAP: return (addr & ~win_mask) | (inc & win_mask);
      default:    return addr;
    endcase
  endfunction

  wstate_t           wstate_r, wstate_n;
  logic              awready_r, wready_r, bvalid_r, werr_r;
  logic [ID_W-1:0]   wid_r, bid_r;
  logic [1:0]        bresp_r, wburst_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [3:0]        wlen_r, wbeat_r;
  logic [2:0]        wsize_r;
  logic              aw_hs_s, w_hs_s, b_hs_s, wlast_beat_s, wbeat_err_s, wproto_err_s;

  assign aw_hs_s      = awvalid & awready_r;
  assign w_hs_s       = wvalid & wready_r;
  assign b_hs_s       = bvalid_r & bready;
  assign wlast_beat_s = (wbeat_r == wlen_r);
  assign wbeat_err_s  = cfg_err(wsize_r, wburst_r, wlen_r) | idx_err(waddr_r);
  assign wproto_err_s = (wlast != wlast_beat_s) | (wid != wid_r);

  // Write FSM next state
  always_comb begin
    wstate_n = wstate_r;
    case (wstate_r)
      W_IDLE:  if (aw_hs_s) wstate_n = W_DATA; else wstate_n = W_IDLE;
      W_DATA:  if (w_hs_s && wlast_beat_s) wstate_n = W_RESP; else wstate_n = W_DATA;
      W_RESP:  if (b_hs_s) wstate_n = W_IDLE; else wstate_n = W_RESP;
      default: wstate_n = W_IDLE;
    endcase
  end

  // Write state, handshake outputs and burst context
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wstate_r  <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {ID_W{1'b0}};
      bresp_r   <= RESP_OKAY;
      wid_r     <= {ID_W{1'b0}};
      waddr_r   <= {ADDR_W{1'b0}};
      wlen_r    <= 4'd0;
      wsize_r   <= 3'd0;
      wburst_r  <= 2'b00;
      wbeat_r   <= 4'd0;
      werr_r    <= 1'b0;
    end else begin
      wstate_r  <= wstate_n;
      awready_r <= (wstate_n == W_IDLE);
      wready_r  <= (wstate_n == W_DATA);
      bvalid_r  <= (wstate_n == W_RESP);
      if (aw_hs_s) begin
        wid_r    <= awid;
        waddr_r  <= awaddr;
        wlen_r   <= awlen;
        wsize_r  <= awsize;
        wburst_r <= awburst;
        wbeat_r  <= 4'd0;
        werr_r   <= 1'b0;
      end else if (w_hs_s) begin
        waddr_r <= next_addr(waddr_r, wsize_r, wlen_r, wburst_r);
        wbeat_r <= wbeat_r + 4'd1;
        werr_r  <= werr_r | wbeat_err_s | wproto_err_s;
        if (wlast_beat_s) begin
          bid_r   <= wid_r;
          bresp_r <= (werr_r | wbeat_err_s | wproto_err_s) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-lane memory writes; the array is deliberately left out of reset
  always_ff @(posedge aclk) begin
    if (w_hs_s && !wbeat_err_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[word_idx(waddr_r)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  rstate_t           rstate_r, rstate_n;
  logic              arready_r, rvalid_r, rlast_r;
  logic [ID_W-1:0]   rid_r;
  logic [1:0]        rresp_r, rburst_r, rburst_s;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] raddr_r, rbeat_addr_s;
  logic [3:0]        rlen_r, rbeat_r, rlen_s, rbeat_num_s;
  logic [2:0]        rsize_r, rsize_s;
  logic              ar_hs_s, r_hs_s, rload_s, rbeat_err_s;

  assign ar_hs_s = arvalid & arready_r;
  assign r_hs_s  = rvalid_r & rready;
  assign rload_s = ar_hs_s | (r_hs_s & ~rlast_r);

  // Pick the burst context for the beat being loaded: fresh AR or the latched burst
  always_comb begin
    rbeat_addr_s = raddr_r;
    rsize_s      = rsize_r;
    rlen_s       = rlen_r;
    rburst_s     = rburst_r;
    rbeat_num_s  = rbeat_r;
    if (ar_hs_s) begin
      rbeat_addr_s = araddr;
      rsize_s      = arsize;
      rlen_s       = arlen;
      rburst_s     = arburst;
      rbeat_num_s  = 4'd0;
    end else begin
      rbeat_addr_s = raddr_r;
      rbeat_num_s  = rbeat_r;
    end
    rbeat_err_s = cfg_err(rsize_s, rburst_s, rlen_s) | idx_err(rbeat_addr_s);
  end

  // Read FSM next state
  always_comb begin
    rstate_n = rstate_r;
    case (rstate_r)
      R_IDLE:  if (ar_hs_s) rstate_n = R_DATA; else rstate_n = R_IDLE;
      R_DATA:  if (r_hs_s && rlast_r) rstate_n = R_IDLE; else rstate_n = R_DATA;
      default: rstate_n = R_IDLE;
    endcase
  end

  // Read state and R output registers; mem is sampled before any same-edge write lands
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rstate_r  <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= {ID_W{1'b0}};
      rresp_r   <= RESP_OKAY;
      rdata_r   <= {DATA_W{1'b0}};
      raddr_r   <= {ADDR_W{1'b0}};
      rlen_r    <= 4'd0;
      rsize_r   <= 3'd0;
      rburst_r  <= 2'b00;
      rbeat_r   <= 4'd0;
    end else begin
      rstate_r  <= rstate_n;
      arready_r <= (rstate_n == R_IDLE);
      rvalid_r  <= (rstate_n == R_DATA);
      if (ar_hs_s) begin
        rid_r    <= arid;
        rlen_r   <= arlen;
        rsize_r  <= arsize;
        rburst_r <= arburst;
      end
      if (rload_s) begin
        rdata_r <= rbeat_err_s ? {DATA_W{1'b0}} : mem[word_idx(rbeat_addr_s)];
        rresp_r <= rbeat_err_s ? RESP_SLVERR : RESP_OKAY;
        rlast_r <= (rbeat_num_s == rlen_s);
        raddr_r <= next_addr(rbeat_addr_s, rsize_s, rlen_s, rburst_s);
        rbeat_r <= rbeat_num_s + 4'd1;
      end else if (r_hs_s) begin
        rlast_r <= 1'b0;
      end
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bid     = bid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rlast   = rlast_r;
  assign rid     = rid_r;
  assign rresp   = rresp_r;
  assign rdata   = rdata_r;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised scoreboard bench for axi_slave_mem: stimulus pushes expected B/R
// responses computed from a byte-level reference memory; a monitor pops and compares.
module tb_axi_slave_mem;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, DEPTH = 1024;

  logic aclk = 1'b0;
  logic arst;
  logic [ID_W-1:0] awid, wid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [3:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [DATA_W-1:0] wdata, rdata;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_slave_mem #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  int compared = 0, mismatched = 0;
  int bmode = 0, rmode = 0;  // 0: always ready, 1: random, 2: held low (b) / toggling (r)
  logic [31:0] ref_mem [DEPTH];
  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  int wrap_lens[4] = '{1, 3, 7, 15};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference rules, stated as closed-form arithmetic on the beat number.
  function automatic logic cfg_err(input int size, input int burst, input int len);
    return size > 2 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int size, input int len,
                                            input int burst, input int i);
    longint unsigned aa, b, win, base;
    aa = a;
    b  = 64'd1 << size;
    if (burst == 0) return a;
    if (burst == 2) begin
      win  = (len + 1) * b;
      base = aa - (aa % win);
      return 32'(base + (aa - base + i * b) % win);
    end
    return 32'(aa + i * b);
  endfunction

  task automatic wait_hs(input string name, input int which);
    bit hs = 1'b0;
    for (int n = 0; n < 300 && !hs; n++) begin
      @(negedge aclk);
      case (which)
        0:       hs = awready;
        1:       hs = wready;
        default: hs = arready;
      endcase
      @(posedge aclk); #1;
    end
    check(name, hs, 1'b1);
  endtask

  task automatic drain(input bit reads_only, input int budget);
    int n = 0;
    while ((exp_r.size() != 0 || (!reads_only && exp_b.size() != 0)) && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    if (exp_r.size() != 0 || (!reads_only && exp_b.size() != 0)) fail("drain");
    @(posedge aclk); #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input bit fix_data,
                          input logic [31:0] fdata, input bit rnd_strb, input logic [3:0] fstrb,
                          input int bad, input int stop_after);
    logic cerr, berr, any_err;
    logic [31:0] ba, d;
    logic [3:0] s;
    b_exp_t be;
    drain(1'b1, 600);
    cerr = cfg_err(size, burst, len);
    any_err = cerr || (bad != 0);
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(addr, size, len, burst, i);
      if ((ba >> 2) >= DEPTH) any_err = 1'b1;
    end
    if (stop_after < 0) begin
      be.id = id;
      be.resp = any_err ? 2'b10 : 2'b00;
      exp_b.push_back(be);
    end
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    wait_hs("aw_handshake", 0);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (stop_after >= 0 && i == stop_after) begin
        wvalid = 1'b0;
        return;
      end
      if ($urandom_range(3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      ba   = beat_addr(addr, size, len, burst, i);
      berr = cerr || ((ba >> 2) >= DEPTH);
      d    = fix_data ? fdata + 32'(i) : $urandom;
      s    = rnd_strb ? 4'($urandom) : fstrb;
      wid   = (bad == 2) ? ~id : id;
      wlast = (bad == 1) ? (i != len) : (i == len);
      wdata = d; wstrb = s; wvalid = 1'b1;
      wait_hs("w_handshake", 1);
      if (!berr) begin
        for (int k = 0; k < 4; k++) if (s[k]) ref_mem[ba[11:2]][8*k +: 8] = d[8*k +: 8];
      end
      if (i == len) check("b_latency", bvalid, 1'b1);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    logic cerr, berr;
    logic [31:0] ba;
    r_exp_t re;
    cerr = cfg_err(size, burst, len);
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(addr, size, len, burst, i);
      berr = cerr || ((ba >> 2) >= DEPTH);
      re.id = id;
      re.data = berr ? 32'h0 : ref_mem[ba[11:2]];
      re.resp = berr ? 2'b10 : 2'b00;
      re.last = (i == len);
      exp_r.push_back(re);
    end
    arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    wait_hs("ar_handshake", 2);
    arvalid = 1'b0;
  endtask

  // Ready generators
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (bmode)
        0:       bready = 1'b1;
        1:       bready = 1'($urandom);
        default: bready = 1'b0;
      endcase
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom);
        default: rready = ~rready;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  initial begin : monitor
    b_exp_t be;
    r_exp_t re;
    logic b_hold, r_hold;
    logic [6:0] b_prev;
    logic [39:0] r_prev;
    b_hold = 1'b0; r_hold = 1'b0; b_prev = 7'd0; r_prev = 40'd0;
    forever begin
      @(negedge aclk);
      if (arst) begin
        b_hold = 1'b0;
        r_hold = 1'b0;
      end else begin
        if (b_hold) check("b_stable", {bvalid, bid, bresp}, b_prev);
        if (r_hold) check("r_stable", {rvalid, rid, rresp, rlast, rdata}, r_prev);
        if (bvalid && bready) begin
          if (exp_b.size() == 0) fail("b_unexpected");
          else begin
            be = exp_b.pop_front();
            check("bid", bid, be.id);
            check("bresp", bresp, be.resp);
          end
        end
        if (rvalid && rready) begin
          if (exp_r.size() == 0) fail("r_unexpected");
          else begin
            re = exp_r.pop_front();
            check("rid", rid, re.id);
            check("rdata", rdata, re.data);
            check("rresp", rresp, re.resp);
            check("rlast", rlast, re.last);
          end
        end
        b_hold = bvalid && !bready;
        b_prev = {bvalid, bid, bresp};
        r_hold = rvalid && !rready;
        r_prev = {rvalid, rid, rresp, rlast, rdata};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int size, burst, len, sel;
    logic [31:0] addr;
    arst = 1'b1;
    awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rlast,
                            rid, rresp, rdata}, 64'd0);
    arst = 1'b0;

    for (int w = 0; w < DEPTH; w += 16)
      do_write(4'(w / 16), 32'(w * 4), 15, 2, 1, 1'b0, 32'd0, 1'b0, 4'hF, 0, -1);

    // INCR write/readback, strobes, WRAP
    do_write(4'd1, 32'h10, 3, 2, 1, 1'b1, 32'hA0, 1'b0, 4'hF, 0, -1);
    do_read(4'd1, 32'h10, 3, 2, 1);
    do_write(4'd2, 32'h20, 0, 2, 1, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'hF, 0, -1);
    do_write(4'd2, 32'h20, 0, 2, 1, 1'b1, 32'h1234_5678, 1'b0, 4'b0101, 0, -1);
    do_read(4'd2, 32'h20, 0, 2, 1);
    do_write(4'd3, 32'h38, 3, 2, 2, 1'b1, 32'hC0, 1'b0, 4'hF, 0, -1);
    do_read(4'd3, 32'h38, 3, 2, 2);
    do_read(4'd3, 32'h30, 3, 2, 1);
    do_read(4'd3, 32'h34, 2, 2, 0);

    // Error cases
    do_write(4'd4, 32'(DEPTH * 4), 0, 2, 1, 1'b1, 32'hDEAD_0000, 1'b0, 4'hF, 0, -1);
    do_read(4'd4, 32'h0, 0, 2, 1);
    do_read(4'd5, 32'h40, 3, 2, 3);
    do_write(4'd6, 32'h30, 2, 2, 2, 1'b0, 32'd0, 1'b0, 4'hF, 0, -1);
    do_read(4'd6, 32'h30, 2, 2, 2);
    do_write(4'd7, 32'((DEPTH - 2) * 4), 3, 2, 1, 1'b0, 32'd0, 1'b0, 4'hF, 0, -1);
    do_read(4'd7, 32'((DEPTH - 2) * 4), 3, 2, 1);
    do_read(4'd8, 32'h50, 1, 3, 1);
    do_write(4'd9, 32'h60, 1, 2, 1, 1'b0, 32'd0, 1'b0, 4'hF, 1, -1);
    do_write(4'd9, 32'h60, 1, 2, 1, 1'b0, 32'd0, 1'b0, 4'hF, 0, -1);
    do_write(4'd10, 32'h68, 1, 2, 1, 1'b0, 32'd0, 1'b0, 4'hF, 2, -1);
    do_write(4'd10, 32'h68, 1, 2, 1, 1'b0, 32'd0, 1'b0, 4'hF, 0, -1);
    do_read(4'd10, 32'h60, 3, 2, 1);

    // Backpressure on R and B
    drain(1'b0, 1000);
    rmode = 2;
    do_read(4'd11, 32'h80, 7, 2, 1);
    drain(1'b0, 1000);
    rmode = 0;
    bmode = 2;
    do_write(4'd12, 32'hA0, 1, 2, 1, 1'b0, 32'd0, 1'b0, 4'hF, 0, -1);
    repeat (5) @(posedge aclk);
    #1;
    check("b_held", {bvalid, bid, bresp}, {1'b1, 4'd12, 2'b00});
    bmode = 0;
    drain(1'b0, 1000);

    // Reset in the middle of a write burst
    do_write(4'd13, 32'h100, 3, 2, 1, 1'b1, 32'h55AA_0000, 1'b0, 4'hF, 0, 2);
    arst = 1'b1;
    #2;
    check("reset_mid_outputs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rlast,
                                rid, rresp, rdata}, 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    arst = 1'b0;
    do_write(4'd14, 32'h108, 0, 2, 1, 1'b1, 32'h77, 1'b0, 4'hF, 0, -1);
    do_read(4'd14, 32'h100, 3, 2, 1);
    drain(1'b0, 1000);

    // Randomised traffic
    bmode = 1;
    rmode = 1;
    for (int t = 0; t < 60; t++) begin
      sel   = $urandom_range(9);
      size  = (sel == 0) ? 3 : $urandom_range(2);
      burst = (sel == 1) ? 3 : $urandom_range(2);
      len   = $urandom_range(15);
      if (burst == 2 && sel != 2) len = wrap_lens[$urandom_range(3)];
      addr  = (sel == 3) ? 32'((DEPTH - 4) * 4 + $urandom_range(15)) : 32'($urandom_range(DEPTH * 4 - 1));
      if ($urandom_range(1) == 0)
        do_write(4'($urandom), addr, len, size, burst, 1'b0, 32'd0, 1'b1, 4'hF, 0, -1);
      else
        do_read(4'($urandom), addr, len, size, burst);
    end
    bmode = 0;
    rmode = 0;
    drain(1'b0, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
